// File: rtl/booth_mult.sv
// booth_mult -- radix-2 Booth sequential signed multiplier.
//
// One Booth step per clock: a start accepted in IDLE is followed by WIDTH
// RUN cycles and a single DONE cycle, in which HI/LO carry the full signed
// product and mult_done pulses. HI/LO change only when DONE is entered and
// then hold until the next product is written.
//
// Optional feature: define BOOTH_MULT_ZERO_BYPASS_EN to send a start with a
// zero operand straight from IDLE to DONE (result 0, RUN skipped). With the
// macro undefined, zero operands take the normal WIDTH+1 cycle path.
module booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mult_start,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             mult_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state_r;
  state_t            next_state_s;

  // Datapath registers: multiplicand, accumulator (one guard bit so that
  // subtracting the most-negative multiplicand cannot overflow), multiplier
  // / low product half, and the Booth history bit q-1.
  logic [WIDTH-1:0]  mcand_r;
  logic [WIDTH:0]    acc_r;
  logic [WIDTH-1:0]  q_r;
  logic              q_m1_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [WIDTH-1:0]  hi_r;
  logic [WIDTH-1:0]  lo_r;
  logic              done_r;
  logic              busy_r;

  logic [WIDTH:0]    m_ext_s;
  logic [WIDTH:0]    sum_s;
  logic [WIDTH:0]    acc_next_s;
  logic [WIDTH-1:0]  q_next_s;
  logic              q_m1_next_s;
  logic              last_step_s;
  logic              zero_op_s;

`ifdef BOOTH_MULT_ZERO_BYPASS_EN
  assign zero_op_s = (A == {WIDTH{1'b0}}) || (B == {WIDTH{1'b0}});
`else
  assign zero_op_s = 1'b0;
`endif

  assign last_step_s = (cnt_r == CNT_W'(1));

  // One Booth step: add/subtract on the upper half, then arithmetic shift.
  always_comb begin
    m_ext_s = {mcand_r[WIDTH-1], mcand_r};
    sum_s   = acc_r;
    case ({q_r[0], q_m1_r})
      2'b01:   sum_s = acc_r + m_ext_s;
      2'b10:   sum_s = acc_r - m_ext_s;
      default: sum_s = acc_r;
    endcase
    acc_next_s  = {sum_s[WIDTH], sum_s[WIDTH:1]};
    q_next_s    = {sum_s[0], q_r[WIDTH-1:1]};
    q_m1_next_s = q_r[0];
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; starts are only looked at in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mult_start) begin
          if (zero_op_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = RUN;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (last_step_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand capture, Booth iteration and result write on DONE entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mcand_r <= {WIDTH{1'b0}};
      acc_r   <= {(WIDTH+1){1'b0}};
      q_r     <= {WIDTH{1'b0}};
      q_m1_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (mult_start) begin
            mcand_r <= A;
            q_r     <= B;
            acc_r   <= {(WIDTH+1){1'b0}};
            q_m1_r  <= 1'b0;
            cnt_r   <= CNT_W'(WIDTH);
            if (zero_op_s) begin
              hi_r <= {WIDTH{1'b0}};
              lo_r <= {WIDTH{1'b0}};
            end
          end
        end
        RUN: begin
          acc_r  <= acc_next_s;
          q_r    <= q_next_s;
          q_m1_r <= q_m1_next_s;
          cnt_r  <= cnt_r - CNT_W'(1);
          if (last_step_s) begin
            // Product fits in 2*WIDTH bits; the guard bit is only sign.
            hi_r <= acc_next_s[WIDTH-1:0];
            lo_r <= q_next_s;
          end
        end
        DONE: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Registered status flags derived from the state being entered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= (next_state_s == DONE);
      busy_r <= (next_state_s != IDLE);
    end
  end

  assign HI        = hi_r;
  assign LO        = lo_r;
  assign mult_done = done_r;
  assign busy      = busy_r;

endmodule

// File: doc/booth_mult.md
BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width and the width of each result half.
REQ-002 Port clock SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide, and be synchronous and active-low.
REQ-004 Port A SHALL be an input, WIDTH bits wide, carrying the signed multiplicand.
REQ-005 Port B SHALL be an input, WIDTH bits wide, carrying the signed multiplier.
REQ-006 Port mult_start SHALL be an input, 1 bit wide, requesting a new multiplication.
REQ-007 Port HI SHALL be an output, WIDTH bits wide, carrying the upper half of the signed product, driven from a register.
REQ-008 Port LO SHALL be an output, WIDTH bits wide, carrying the lower half of the signed product, driven from a register.
REQ-009 Port mult_done SHALL be an output, 1 bit wide, pulsing high for one cycle when HI/LO become valid.
REQ-010 Port busy SHALL be an output, 1 bit wide, high while a multiplication is in progress.

Function
REQ-011 The block SHALL implement a radix-2 Booth sequential multiplier with FSM states IDLE, RUN and DONE.
REQ-012 In IDLE with mult_start=1 (cycle 0), the block SHALL capture A and B into internal registers, clear the accumulator and Booth bit, load the step counter with WIDTH, and go to RUN.
REQ-013 In RUN, each cycle SHALL perform one Booth step and decrement the counter.
- Booth pair 01: add multiplicand to the upper half.
- Booth pair 10: subtract multiplicand from the upper half.
- Booth pair 00 or 11: no add.
- Then arithmetic right shift of {acc, Q, q-1} by 1.
REQ-014 After exactly WIDTH RUN cycles (cycles 1..WIDTH), the FSM SHALL enter DONE in cycle WIDTH+1; in DONE HI/LO SHALL hold the full 2*WIDTH-bit signed product and mult_done SHALL be 1.
REQ-015 DONE SHALL last exactly one cycle, then return to IDLE; HI/LO SHALL hold their value until the next accepted start.
REQ-016 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-017 mult_start SHALL be accepted only in IDLE; it SHALL be ignored in RUN and DONE, with no restart and no effect on the result.
REQ-018 Changes on A/B after capture SHALL not affect the result in progress.
REQ-019 HI/LO SHALL be written only on DONE entry; intermediate values SHALL not appear on HI/LO.
REQ-020 The most-negative operand (0x80000000 at WIDTH=32) SHALL produce the correct product, using a WIDTH+1-bit internal accumulator so that subtraction does not overflow.

Reset
REQ-021 When reset=0 at a rising edge, the block SHALL go to IDLE and set HI=0, LO=0, mult_done=0, busy=0, the counter to 0 and the internal registers to 0.
REQ-022 Reset in RUN or DONE SHALL abort the operation with no mult_done pulse; reset SHALL take priority over mult_start in the same cycle.

Configuration
REQ-023 Macro BOOTH_MULT_ZERO_BYPASS_EN, when defined, SHALL enable the zero bypass: a start accepted with A==0 or B==0 goes directly IDLE->DONE, so DONE occurs in cycle 1 with HI=0, LO=0, mult_done=1 and RUN skipped.
REQ-024 When BOOTH_MULT_ZERO_BYPASS_EN is undefined, zero operands SHALL take the full WIDTH+1-cycle path with the same result values.

Verification
REQ-025 A=3, B=5, start at cycle 0 -> mult_done=1 at cycle 33, HI=0x00000000, LO=0x0000000F, busy=0 at cycle 34.
REQ-026 A=0xFFFFFFFF (-1), B=1 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF; A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
REQ-027 A=7, B=6 with start; mult_start re-pulsed with A=2, B=2 at cycle 10 -> single mult_done at cycle 33, HI=0, LO=0x2A.
REQ-028 A=-4 (0xFFFFFFFC), B=9 -> HI=0xFFFFFFFF, LO=0xFFFFFFDC.
REQ-029 Start A=3, B=5, then reset=0 at cycle 12 -> HI=LO=0, busy=0, no mult_done; a new start after reset yields the correct product at cycle 33 relative to that start.
REQ-030 A=0, B=123 -> with BOOTH_MULT_ZERO_BYPASS_EN defined, mult_done at cycle 1; without it, mult_done at cycle 33; HI=LO=0 in both cases.
